pixel_capture_module: RTL

- Consumes the one-CLK-cycle PCLK rising-edge pulse from the PCLK edge detector, together with the OV7620 VSYNC, HREF and 8-bit data pins.
- Captures exactly one full frame per start request.
- Packs byte pairs into 16-bit words and issues a write strobe and linear address to the downstream frame RAM.
- Reports frame completion and a sticky geometry/overflow error.

---
 rtl/pixel_capture_module_pkg.sv | 16 +
 rtl/pixel_capture_module_pack.sv | 61 ++++++
 rtl/pixel_capture_module.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pixel_capture_module_pkg.sv
// Shared definitions for the OV7620 capture path: capture FSM encoding and
// the default frame geometry also used by the frame RAM and display modules.
package pixel_capture_module_pkg;

  localparam int DEF_H_BYTES = 640;
  localparam int DEF_V_LINES = 480;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_VS = 3'd1,
    ST_WAIT_VE = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } cap_state_t;

endpackage

// File: rtl/pixel_capture_module_pack.sv
// Byte-pair packer: holds the first byte of each pair and emits a 16-bit
// {first, second} word with a one-cycle write strobe. The word address
// advances the cycle after each strobe, so the first word lands at 0.
// Ports:
//   CLK, RSTn       clock, async active-low reset
//   clr             restart packing at address 0 (accepted capture start)
//   line_end        HREF fall: drop any half-assembled pair
//   byte_vld        accept byte_in this cycle
//   byte_in         camera byte
//   Wr_En/Wr_Addr/Wr_Data  frame RAM write port
//   toggle          1 while a first byte is being held
module pixel_pack_module
  import pixel_capture_module_pkg::*;
#(
  parameter int ADDR_W = 18
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              clr,
  input  logic              line_end,
  input  logic              byte_vld,
  input  logic [7:0]        byte_in,
  output logic              Wr_En,
  output logic [ADDR_W-1:0] Wr_Addr,
  output logic [15:0]       Wr_Data,
  output logic              toggle
);

  logic [7:0] hold;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      Wr_En   <= 1'b0;
      Wr_Addr <= '0;
      Wr_Data <= '0;
      toggle  <= 1'b0;
      hold    <= '0;
    end else begin
      Wr_En <= 1'b0;
      if (clr) begin
        Wr_Addr <= '0;
        toggle  <= 1'b0;
      end else begin
        if (Wr_En) Wr_Addr <= Wr_Addr + ADDR_W'(1);
        if (line_end) begin
          toggle <= 1'b0;
        end else if (byte_vld) begin
          if (toggle) begin
            Wr_Data <= {hold, byte_in};
            Wr_En   <= 1'b1;
            toggle  <= 1'b0;
          end else begin
            hold   <= byte_in;
            toggle <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/pixel_capture_module.sv
// Single-frame OV7620 capture controller. Waits for a full VSYNC pulse after
// a start request, then packs H_BYTES bytes per HREF line for V_LINES lines
// into 16-bit words for the frame RAM. Geometry faults raise a sticky error.
// Ports:
//   CLK, RSTn            clock, async active-low reset
//   L2H_Sig_P            one-CLK PCLK rising-edge pulse (sample enable)
//   Pin_VSYNC/HREF/Data  raw camera pins, registered once here
//   Start_Sig            capture request (ignored unless idle)
//   Wr_En/Wr_Addr/Wr_Data frame RAM write port
//   Busy_Sig, Done_Sig, Err_Sig  status
//
// state      | meaning
// IDLE       | waiting for Start_Sig, camera ignored
// WAIT_VS    | waiting for VSYNC rise (skip any frame already in progress)
// WAIT_VE    | waiting for VSYNC fall, frame data follows
// CAPTURE    | packing HREF bytes, counting columns and rows
// DONE       | one-cycle completion pulse
module pixel_capture_module
  import pixel_capture_module_pkg::*;
#(
  parameter int H_BYTES = DEF_H_BYTES,
  parameter int V_LINES = DEF_V_LINES,
  parameter int ADDR_W  = 18
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              L2H_Sig_P,
  input  logic              Pin_VSYNC,
  input  logic              Pin_HREF,
  input  logic [7:0]        Pin_Data,
  input  logic              Start_Sig,
  output logic              Wr_En,
  output logic [ADDR_W-1:0] Wr_Addr,
  output logic [15:0]       Wr_Data,
  output logic              Busy_Sig,
  output logic              Done_Sig,
  output logic              Err_Sig
);

  localparam int COL_W = $clog2(H_BYTES + 1);
  localparam int ROW_W = $clog2(V_LINES + 1);
  localparam logic [COL_W-1:0] COL_FULL = COL_W'(H_BYTES);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_LINES - 1);

  cap_state_t state, state_nxt;

  logic       vs_d1, href_d1, vs_p, href_p;
  logic [7:0] data_d1;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic start_acc, capturing, toggle;
  logic vs_rise, vs_fall, href_fall;
  logic byte_acc, overrun, line_err, short_err, last_line;

  // One register stage puts the pins in the same cycle as L2H_Sig_P.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      vs_d1   <= 1'b0;
      href_d1 <= 1'b0;
      data_d1 <= '0;
      vs_p    <= 1'b0;
      href_p  <= 1'b0;
    end else begin
      vs_d1   <= Pin_VSYNC;
      href_d1 <= Pin_HREF;
      data_d1 <= Pin_Data;
      if (L2H_Sig_P) begin
        vs_p   <= vs_d1;
        href_p <= href_d1;
      end
    end
  end

  assign vs_rise   = L2H_Sig_P & ~vs_p & vs_d1;
  assign vs_fall   = L2H_Sig_P & vs_p & ~vs_d1;
  assign href_fall = L2H_Sig_P & href_p & ~href_d1;

  assign capturing = (state == ST_CAPTURE);
  assign last_line = href_fall & (row == ROW_LAST);
  assign byte_acc  = capturing & L2H_Sig_P & href_d1 & (col != COL_FULL);
  assign overrun   = capturing & L2H_Sig_P & href_d1 & (col == COL_FULL);
  assign line_err  = capturing & href_fall & ((col != COL_FULL) | toggle);
  // A VSYNC rise landing on the sample that finishes the last line is a
  // normal end of frame, not a short one.
  assign short_err = capturing & vs_rise & ~last_line;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Start_Sig) begin
          state_nxt = ST_WAIT_VS;
          start_acc = 1'b1;
        end
      end
      ST_WAIT_VS: if (vs_rise) state_nxt = ST_WAIT_VE;
      ST_WAIT_VE: if (vs_fall) state_nxt = ST_CAPTURE;
      ST_CAPTURE: begin
        if (last_line || vs_rise) state_nxt = ST_DONE;
      end
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      col      <= '0;
      row      <= '0;
      Busy_Sig <= 1'b0;
      Err_Sig  <= 1'b0;
    end else begin
      if (start_acc) begin
        col <= '0;
        row <= '0;
      end else if (capturing) begin
        if (href_fall) begin
          col <= '0;
          row <= row + ROW_W'(1);
        end else if (byte_acc) begin
          col <= col + COL_W'(1);
        end
      end

      if (start_acc)              Busy_Sig <= 1'b1;
      else if (state == ST_DONE)  Busy_Sig <= 1'b0;

      if (start_acc)                              Err_Sig <= 1'b0;
      else if (overrun || line_err || short_err)  Err_Sig <= 1'b1;
    end
  end

  assign Done_Sig = (state == ST_DONE);

  pixel_pack_module #(.ADDR_W(ADDR_W)) u_pack (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .clr      (start_acc),
    .line_end (capturing & href_fall),
    .byte_vld (byte_acc),
    .byte_in  (data_d1),
    .Wr_En    (Wr_En),
    .Wr_Addr  (Wr_Addr),
    .Wr_Data  (Wr_Data),
    .toggle   (toggle)
  );

endmodule
